// File: rtl/vend_controller.sv
// vend_controller
//   Transaction sequencer for the vending machine. Accumulates coin credit,
//   validates selections against a packed price list and per-product stock
//   flags, drives the dispense motor through a vend_req/vend_ack handshake,
//   then returns change as one 5-unit chg_pulse per cycle.
//
// Optional feature: define VEND_TIMEOUT_EN to enable an idle counter that
//   auto-refunds credit after TIMEOUT_CYC quiet cycles in CREDIT.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   coin_valid   single-cycle coin strobe, value on coin_val
//                (00=5, 01=10, 10=25, 11=100)
//   sel_valid    single-cycle selection strobe, product on sel_id
//   cancel       single-cycle refund request
//   stock_empty  per-product sold-out flags
//   vend_req     dispense request, held until vend_ack
//   vend_id      product being dispensed
//   vend_ack     motor-done strobe
//   coin_rej     pulse: previous-cycle coin was rejected
//   chg_pulse    one cycle per 5-unit change coin
//   credit       current credit in units
//   busy         high in VEND or CHANGE
//   err_soldout  pulse: selected product is sold out
//   err_funds    pulse: insufficient credit for selection
module vend_controller #(
    parameter int unsigned        NPROD       = 4,
    parameter logic [8*NPROD-1:0] PRICE_LIST  = 32'h644B3219,
    parameter logic [7:0]         MAX_CREDIT  = 8'd200,
    parameter logic [15:0]        TIMEOUT_CYC = 16'd1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coin_valid,
    input  logic [1:0]               coin_val,
    input  logic                     sel_valid,
    input  logic [$clog2(NPROD)-1:0] sel_id,
    input  logic                     cancel,
    input  logic [NPROD-1:0]         stock_empty,
    output logic                     vend_req,
    output logic [$clog2(NPROD)-1:0] vend_id,
    input  logic                     vend_ack,
    output logic                     coin_rej,
    output logic                     chg_pulse,
    output logic [7:0]               credit,
    output logic                     busy,
    output logic                     err_soldout,
    output logic                     err_funds
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    state_t state;

    function automatic logic [7:0] coin_units(input logic [1:0] code);
        case (code)
            2'b00:   return 8'd5;
            2'b01:   return 8'd10;
            2'b10:   return 8'd25;
            default: return 8'd100;
        endcase
    endfunction

    logic [7:0] price;
    logic [8:0] coin_sum;     // one extra bit so the limit check cannot wrap
    logic       coin_fits;
    logic       sel_accept;
    logic       refund;       // cancel in CREDIT, or idle timeout

    assign price      = PRICE_LIST[{sel_id, 3'b000} +: 8];
    assign coin_sum   = {1'b0, credit} + {1'b0, coin_units(coin_val)};
    assign coin_fits  = (coin_sum <= {1'b0, MAX_CREDIT});
    assign sel_accept = sel_valid && (state == CREDIT) &&
                        !stock_empty[sel_id] && (credit >= price);

`ifdef VEND_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        timeout_hit;

    // Counts quiet cycles in CREDIT; any front-end activity restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != CREDIT || coin_valid || sel_valid || cancel) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Fires on the cycle the counter is about to reach TIMEOUT_CYC.
    assign timeout_hit = (state == CREDIT) && !coin_valid && !sel_valid &&
                         !cancel && (idle_cnt == TIMEOUT_CYC - 16'd1);
    assign refund      = (state == CREDIT) && (cancel || timeout_hit);
`else
    // Timeout disabled: parameter kept for interface compatibility only.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign refund         = (state == CREDIT) && cancel;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            vend_req    <= 1'b0;
            vend_id     <= '0;
            coin_rej    <= 1'b0;
            chg_pulse   <= 1'b0;
            credit      <= 8'd0;
            busy        <= 1'b0;
            err_soldout <= 1'b0;
            err_funds   <= 1'b0;
        end else begin
            coin_rej    <= 1'b0;
            err_soldout <= 1'b0;
            err_funds   <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (refund) begin
                        coin_rej  <= coin_valid;
                        chg_pulse <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CHANGE;
                    end else if (cancel) begin
                        // Cancel in IDLE does nothing but still outranks the coin.
                        coin_rej <= coin_valid;
                    end else begin
                        if (sel_valid) begin
                            if (state == IDLE)             err_funds   <= 1'b1;
                            else if (stock_empty[sel_id])  err_soldout <= 1'b1;
                            else if (credit < price)       err_funds   <= 1'b1;
                        end
                        if (sel_accept) begin
                            credit   <= credit - price;
                            vend_id  <= sel_id;
                            vend_req <= 1'b1;
                            busy     <= 1'b1;
                            state    <= VEND;
                            coin_rej <= coin_valid;
                        end else if (coin_valid) begin
                            if (coin_fits) begin
                                credit <= coin_sum[7:0];
                                state  <= CREDIT;
                            end else begin
                                coin_rej <= 1'b1;
                            end
                        end
                    end
                end
                VEND: begin
                    coin_rej <= coin_valid;
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        if (credit != 8'd0) begin
                            chg_pulse <= 1'b1;
                            state     <= CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin // CHANGE: credit shown this cycle is being paid out
                    coin_rej <= coin_valid;
                    credit   <= credit - 8'd5;
                    if (credit == 8'd5) begin
                        chg_pulse <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        chg_pulse <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
